// File: rtl/ram_port_sequencer.sv
// Sequences a dual-port RAM: zero-fills every word after reset, then passes writes
// straight to port A and issues credit-limited reads on port B into an in-order response FIFO.
module ram_port_sequencer #(
  parameter int AW        = 6,
  parameter int DW        = 16,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dia,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_dob
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] init_cnt_q;
  logic          collision;
  logic          credit_ok;
  logic [CW:0]   credit_used;

  logic          vld_p1;
  logic [DW-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] occ_q;
  logic          push;
  logic          pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end
    end
  end

  // Credit covers both buffered responses and the read still coming back from the RAM.
  assign collision   = wr_valid & rd_valid & (wr_addr == rd_addr);
  assign credit_used = {1'b0, occ_q} + {{CW{1'b0}}, vld_p1};
  assign credit_ok   = credit_used < (CW+1)'(RSP_DEPTH);

  always_comb begin
    state_d   = state_q;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dia   = '0;
    unique case (state_q)
      INIT: begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = init_cnt_q;
        if (init_cnt_q == {AW{1'b1}}) begin
          state_d = RUN;
        end
      end
      RUN: begin
        wr_ready  = 1'b1;
        rd_ready  = ~collision & credit_ok;
        ram_ena   = wr_valid;
        ram_wea   = wr_valid;
        ram_addra = wr_addr;
        ram_dia   = wr_data;
      end
    endcase
  end

  // p0: read handshake drives RAM port B
  assign ram_enb   = rd_valid & rd_ready;
  assign ram_addrb = rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= ram_enb;
    end
  end

  // p1: registered RAM data lands in the response FIFO
  assign push      = vld_p1;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_valid = (occ_q != '0);
  assign rsp_data  = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ram_dob;
    end
  end

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Bench for ram_port_sequencer: bench-side RAM, directed vector table, corner-case
// sequences and random traffic checked against a queue-based reference model.
module tb_ram_port_sequencer;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NW    = 64;
  localparam int NV    = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dia;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob;

  ram_port_sequencer #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  always #5 clk = ~clk;

  // Registered-read dual-port RAM attached to the DUT.
  logic [DW-1:0] bram [NW];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) bram[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= bram[ram_addrb];
  end

  int errors = 0;
  int checks = 0;

  // Reference model: cycle count since reset release, memory image, and the list of
  // accepted reads (data captured at acceptance, plus acceptance cycle).
  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } ent_t;

  int            cyc = 0;
  ent_t          q[$];
  logic [DW-1:0] shadow [NW];
  int            init_writes = 0;
  bit            dut_rd_hs;
  bit            dut_rsp_hs;
  logic [DW-1:0] rsp_dut;

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rv;
    logic [AW-1:0] ra;
    logic          rr;
    logic          e_rdy;
    logic          e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic model_cycle();
    bit run, coll, rdy, enb, rspv;
    run  = (cyc >= NW);
    coll = wr_valid && rd_valid && (wr_addr == rd_addr);
    rdy  = run && !coll && (q.size() < DEPTH);
    enb  = rd_valid && rdy;
    rspv = 1'b0;
    if (q.size() > 0) rspv = (q[0].c <= cyc - 2);

    chk("wr_ready", 32'(wr_ready), 32'(run));
    chk("rd_ready", 32'(rd_ready), 32'(rdy));
    chk("ram_enb", 32'(ram_enb), 32'(enb));
    if (enb) chk("ram_addrb", 32'(ram_addrb), 32'(rd_addr));
    chk("ram_ena", 32'(ram_ena), 32'(run ? wr_valid : 1'b1));
    chk("ram_wea", 32'(ram_wea), 32'(run ? wr_valid : 1'b1));
    if (!run || wr_valid) begin
      chk("ram_addra", 32'(ram_addra), run ? 32'(wr_addr) : 32'(cyc));
      chk("ram_dia", 32'(ram_dia), run ? 32'(wr_data) : 32'd0);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(rspv));
    if (rspv) chk("rsp_data", 32'(rsp_data), 32'(q[0].d));

    if (!run && ram_ena && ram_wea && ram_dia == '0) init_writes++;
    dut_rd_hs  = rd_valid && rd_ready;
    dut_rsp_hs = rsp_valid && rsp_ready;
    rsp_dut    = rsp_data;

    if (rspv && rsp_ready) void'(q.pop_front());
    if (enb) q.push_back('{d: shadow[rd_addr], c: cyc});
    if (!run) shadow[cyc[AW-1:0]] = '0;
    else if (wr_valid) shadow[wr_addr] = wr_data;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_ready", 32'(rd_ready), 32'd0);
    chk("rst_ram_enb", 32'(ram_enb), 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    cyc         = 0;
    init_writes = 0;
    q.delete();
  endtask

  task automatic run_init();
    repeat (NW) step();
    chk("init_zero_writes", 32'(init_writes), 32'd64);
  endtask

  initial begin
    int k;
    int n;
    int stale;
    int nz;

    tbl[0]  = '{1'b1, 6'd10, 16'hBEEF, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 16'hBEEF};
    tbl[4]  = '{1'b1, 6'd3,  16'h1234, 1'b1, 6'd3,  1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd3,  1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 16'h1234};
    tbl[8]  = '{1'b1, 6'd20, 16'h00AA, 1'b1, 6'd5,  1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[9]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 16'h0000};

    do_reset();
    rsp_ready = 1'b1;
    run_init();
    chk("run_wr_ready", 32'(wr_ready), 32'd1);
    chk("run_rd_ready", 32'(rd_ready), 32'd1);
    repeat (2) step();

    for (int i = 0; i < NV; i++) begin
      wr_valid  = tbl[i].wv;
      wr_addr   = tbl[i].wa;
      wr_data   = tbl[i].wd;
      rd_valid  = tbl[i].rv;
      rd_addr   = tbl[i].ra;
      rsp_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_rd_ready", i), 32'(rd_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].e_rd));
      model_cycle();
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;

    // Fill addresses 0..7 so response order is visible.
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 6'(i);
      wr_data  = 16'(16'h0100 + i);
      step();
    end
    wr_valid = 1'b0;

    // Backpressured stream: credit limit stops acceptance at the FIFO depth.
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      rd_valid = 1'b1;
      rd_addr  = 6'(k);
      step();
      if (dut_rd_hs) k++;
    end
    chk("full_accepted", 32'(k), 32'd4);
    chk("full_rd_ready", 32'(rd_ready), 32'd0);
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      rd_valid = (k < 8);
      rd_addr  = 6'(k);
      step();
      if (dut_rd_hs) k++;
      if (dut_rsp_hs) begin
        chk($sformatf("order%0d", n), 32'(rsp_dut), 32'(16'h0100 + n));
        n++;
      end
    end
    rd_valid = 1'b0;
    chk("order_count", 32'(n), 32'd8);
    repeat (3) step();

    // Back-to-back reads wrap the FIFO pointers several times.
    k = 0;
    n = 0;
    for (int c = 0; c < 24; c++) begin
      rd_valid = 1'b1;
      rd_addr  = 6'(c);
      step();
      if (dut_rd_hs) k++;
      if (dut_rsp_hs) n++;
    end
    rd_valid = 1'b0;
    repeat (4) begin
      step();
      if (dut_rsp_hs) n++;
    end
    chk("b2b_accepted", 32'(k), 32'd24);
    chk("b2b_responses", 32'(n), 32'd24);

    for (int c = 0; c < 1500; c++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_addr   = 6'($urandom_range(0, 7));
      wr_data   = 16'($urandom);
      rd_valid  = 1'($urandom_range(0, 1));
      rd_addr   = 6'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset with responses pending: nothing stale may appear afterwards.
    wr_valid  = 1'b0;
    rd_valid  = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1;
      rd_addr  = 6'(i + 10);
      step();
    end
    rd_valid = 1'b0;
    repeat (3) step();
    chk("pending_rsp_valid", 32'(rsp_valid), 32'd1);
    do_reset();
    rsp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < NW + 10; c++) begin
      step();
      if (dut_rsp_hs) stale++;
    end
    chk("no_stale_rsp", 32'(stale), 32'd0);
    chk("reinit_zero_writes", 32'(init_writes), 32'd64);
    nz = 0;
    for (int i = 0; i < NW; i++) if (bram[i] != '0) nz++;
    chk("ram_cleared", 32'(nz), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/ram_port_sequencer.md
RAM_PORT_SEQUENCER -- requirements
Module: ram_port_sequencer

Interface
REQ-001 Parameter AW, default 6, SHALL set the RAM address width (64 words).
REQ-002 Parameter DW, default 16, SHALL set the data width.
REQ-003 Parameter RSP_DEPTH, default 4, SHALL set the response FIFO depth (power of 2, >=2).
REQ-004 Port list (name direction width meaning), one clock; reset is synchronous and active-high:
 clk  in  1  single clock; also drives RAM clka and clkb
 rst  in  1  synchronous active-high reset
 wr_valid  in  1  write request valid
 wr_ready  out  1  write request accepted when valid&ready
 wr_addr  in  AW  write address
 wr_data  in  DW  write data
 rd_valid  in  1  read request valid
 rd_ready  out  1  read request accepted when valid&ready
 rd_addr  in  AW  read address
 rsp_valid  out  1  read response valid
 rsp_ready  in  1  read response consumed when valid&ready
 rsp_data  out  DW  read response data
 ram_ena  out  1  RAM port A enable (write port)
 ram_wea  out  1  RAM port A write enable
 ram_addra  out  AW  RAM port A address
 ram_dia  out  DW  RAM port A write data
 ram_enb  out  1  RAM port B enable (read port)
 ram_addrb  out  AW  RAM port B address
 ram_dob  in  DW  RAM port B registered read data, valid 1 cycle after ram_enb

Function
REQ-005 FSM SHALL have two states: INIT and RUN; rst forces INIT with init counter = 0.
REQ-006 In INIT: ram_ena=ram_wea=1, ram_addra=init counter, ram_dia=0; counter increments by 1 each cycle; wr_ready=rd_ready=0; ram_enb=0.
REQ-007 INIT -> RUN on the cycle the counter equals 2^AW-1 (last zero write); INIT lasts exactly 2^AW cycles.
REQ-008 In RUN, wr_ready SHALL be 1 every cycle (no write backpressure).
REQ-009 In RUN, ram_ena=ram_wea=wr_valid, ram_addra=wr_addr, ram_dia=wr_data, combinationally.
REQ-010 In RUN, rd_ready SHALL be 1 only when (FIFO occupancy + in-flight reads) < RSP_DEPTH and no collision (REQ-011).
REQ-011 Collision: wr_valid=1 and rd_valid=1 with wr_addr==rd_addr in the same cycle SHALL force rd_ready=0; write proceeds, read issues on a later cycle and returns the new data.
REQ-012 ram_enb SHALL equal rd_valid&rd_ready; ram_addrb=rd_addr.
REQ-013 In-flight flag SHALL be set the cycle after a read handshake and cleared otherwise (max 1 in flight).
REQ-014 When in-flight=1, ram_dob SHALL be pushed into the response FIFO at that clock edge.
REQ-015 Latency: rd handshake at cycle N -> rsp_valid=1 with that data at cycle N+2 when FIFO empty.
REQ-016 Responses SHALL be returned in request order; no read is dropped or duplicated.
REQ-017 rsp_valid = FIFO not empty; rsp_data = FIFO head; pop on rsp_valid&rsp_ready.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; push to full FIFO SHALL be impossible by REQ-010 credit rule.
REQ-019 FIFO pointers SHALL wrap modulo RSP_DEPTH; occupancy counter width log2(RSP_DEPTH)+1.
REQ-020 Sustained throughput with rsp_ready=1 and no collisions SHALL be 1 read and 1 write per cycle.

Reset
REQ-021 On rst: state=INIT, init counter=0, in-flight=0, FIFO empty; rsp_valid=0, wr_ready=0, rd_ready=0, ram_enb=0; ram_ena=ram_wea=1, ram_addra=0, ram_dia=0 in the first INIT cycle.
REQ-022 rst asserted mid-RUN or mid-INIT SHALL discard in-flight reads and FIFO contents and restart INIT from address 0.

Verification
REQ-023 Reset then idle -> exactly 64 zero writes to addresses 0..63, then wr_ready=1, rd_ready=1; read addr 5 -> rsp_data=0x0000.
REQ-024 Write 0xBEEF to addr 10, next cycle read addr 10 -> rsp_valid 2 cycles after read handshake, rsp_data=0xBEEF.
REQ-025 Same cycle write 0x1234 to addr 3 and read addr 3 -> rd_ready=0 that cycle, read accepted next cycle, rsp_data=0x1234.
REQ-026 rsp_ready=0, stream reads addrs 0..7 -> exactly 4 accepted, rd_ready=0 after; then rsp_ready=1 -> 8 responses in order 0..7.
REQ-027 Back-to-back reads with rsp_ready=1 -> rd_ready stays 1, one response per cycle, FIFO pointers wrap without loss.
REQ-028 Assert rst with 3 responses pending -> rsp_valid=0 next cycle, no stale response emitted after INIT completes.
